color_cursor_compositor: RTL and testbench



---
 rtl/color_cursor_compositor.sv | 149 ++++++++++++++
 tb/tb_color_cursor_compositor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/color_cursor_compositor.sv
// color_cursor_compositor
//   Holds the brush color (advanced by rising edges of toggle), draws a
//   plus-shaped cursor in that color and merges cursor, four canvas layers
//   and the background into one RGB value per requested pixel.
//   Optional feature macro: CAMERA_BACKGROUND_EN
//     defined   -> background is camera_r/g/b
//     undefined -> background is constant white, camera inputs ignored
module color_cursor_compositor #(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480,
   parameter int COLOR_WIDTH = 3,
   parameter int CURSOR_ARM  = 4,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   toggle,
   input  logic [XW-1:0]          cursor_x,
   input  logic [YW-1:0]          cursor_y,
   input  logic [XW-1:0]          request_x,
   input  logic [YW-1:0]          request_y,
   input  logic                   cursor_visible,
   input  logic [COLOR_WIDTH-1:0] canvas1_color,
   input  logic                   canvas1_visible,
   input  logic [COLOR_WIDTH-1:0] canvas2_color,
   input  logic                   canvas2_visible,
   input  logic [COLOR_WIDTH-1:0] canvas3_color,
   input  logic                   canvas3_visible,
   input  logic [COLOR_WIDTH-1:0] canvas4_color,
   input  logic                   canvas4_visible,
   input  logic [7:0]             camera_r,
   input  logic [7:0]             camera_g,
   input  logic [7:0]             camera_b,
   output logic [COLOR_WIDTH-1:0] current_color,
   output logic [7:0]             render_r,
   output logic [7:0]             render_g,
   output logic [7:0]             render_b
);

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0;
   localparam logic [COLOR_WIDTH-1:0] COLOR_FIRST = COLOR_WIDTH'(1);
   localparam logic [COLOR_WIDTH-1:0] COLOR_LAST  = '1;
   localparam logic [XW:0]            ARM_X       = (XW+1)'(CURSOR_ARM);
   localparam logic [YW:0]            ARM_Y       = (YW+1)'(CURSOR_ARM);
   localparam int                     NUM_LAYERS  = 5;

   // Palette lookup; code 0 never reaches here because transparent layers
   // are skipped before mapping.
   function automatic rgb_t palette(input logic [COLOR_WIDTH-1:0] code);
      rgb_t c;
      case (code)
         COLOR_WIDTH'(1): c = '{8'h00, 8'h00, 8'h00};
         COLOR_WIDTH'(2): c = '{8'hFF, 8'hFF, 8'hFF};
         COLOR_WIDTH'(3): c = '{8'hFF, 8'h00, 8'h00};
         COLOR_WIDTH'(4): c = '{8'h00, 8'hFF, 8'h00};
         COLOR_WIDTH'(5): c = '{8'h00, 8'h00, 8'hFF};
         COLOR_WIDTH'(6): c = '{8'hFF, 8'hFF, 8'h00};
         COLOR_WIDTH'(7): c = '{8'h00, 8'hFF, 8'hFF};
         default:         c = '{8'h00, 8'h00, 8'h00};
      endcase
      return c;
   endfunction

   // ------------------------------------------------------------------
   // Color selector
   // ------------------------------------------------------------------
   logic toggle_q;

   // Brush color steps on toggle rising edges; reset reloads the edge
   // history so a toggle held across reset release does not count.
   always_ff @(posedge clk) begin
      toggle_q <= toggle;
      if (reset) begin
         current_color <= COLOR_FIRST;
      end else if (toggle && !toggle_q) begin
         current_color <= (current_color == COLOR_LAST) ? COLOR_FIRST
                                                        : current_color + COLOR_FIRST;
      end
   end

   // ------------------------------------------------------------------
   // Cursor renderer
   // ------------------------------------------------------------------
   // Differences are taken one bit wider than the coordinates so that
   // positions near an edge clip instead of wrapping to the far side.
   logic signed [XW:0]     dx;
   logic signed [YW:0]     dy;
   logic [XW:0]            adx;
   logic [YW:0]            ady;
   logic                   on_cursor;
   logic [COLOR_WIDTH-1:0] cursor_code;

   // Plus-shape hit test against the current cursor position.
   always_comb begin
      dx          = $signed({1'b0, request_x}) - $signed({1'b0, cursor_x});
      dy          = $signed({1'b0, request_y}) - $signed({1'b0, cursor_y});
      adx         = dx[XW] ? $unsigned(-dx) : $unsigned(dx);
      ady         = dy[YW] ? $unsigned(-dy) : $unsigned(dy);
      on_cursor   = ((dx == '0) && (ady <= ARM_Y)) ||
                    ((dy == '0) && (adx <= ARM_X));
      cursor_code = on_cursor ? current_color : COLOR_NONE;
   end

   // ------------------------------------------------------------------
   // Background
   // ------------------------------------------------------------------
   rgb_t bg;
`ifdef CAMERA_BACKGROUND_EN
   assign bg = '{camera_r, camera_g, camera_b};
`else
   logic unused_camera;
   assign bg            = '{8'hFF, 8'hFF, 8'hFF};
   assign unused_camera = ^{camera_r, camera_g, camera_b};
`endif

   // ------------------------------------------------------------------
   // Compositor
   // ------------------------------------------------------------------
   // Index 0 is lowest priority, NUM_LAYERS-1 highest.
   logic [NUM_LAYERS-1:0][COLOR_WIDTH-1:0] layer_code;
   logic [NUM_LAYERS-1:0]                  layer_vis;
   rgb_t                                   pix;

   assign layer_code = {cursor_code, canvas4_color, canvas3_color,
                        canvas2_color, canvas1_color};
   assign layer_vis  = {cursor_visible, canvas4_visible, canvas3_visible,
                        canvas2_visible, canvas1_visible};

   // Walk layers low to high so the highest participating one wins.
   always_comb begin
      pix = bg;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (layer_vis[i] && (layer_code[i] != COLOR_NONE))
            pix = palette(layer_code[i]);
      end
   end

   assign render_r = pix.r;
   assign render_g = pix.g;
   assign render_b = pix.b;

endmodule

// File: tb/tb_color_cursor_compositor.sv
// Directed bench for color_cursor_compositor: color selector sequence,
// reset/toggle interaction, cursor shape and clipping, layer priority.
module tb_color_cursor_compositor;

   localparam int WIDTH  = 640;
   localparam int HEIGHT = 480;
   localparam int XW     = $clog2(WIDTH);
   localparam int YW     = $clog2(HEIGHT);
   localparam int CW     = 3;

`ifdef CAMERA_BACKGROUND_EN
   localparam logic [23:0] BG = 24'h123456;
`else
   localparam logic [23:0] BG = 24'hFFFFFF;
`endif

   logic          clk = 1'b0;
   logic          reset, toggle;
   logic [XW-1:0] cursor_x, request_x;
   logic [YW-1:0] cursor_y, request_y;
   logic          cursor_visible;
   logic [CW-1:0] c1, c2, c3, c4;
   logic          v1, v2, v3, v4;
   logic [7:0]    camera_r, camera_g, camera_b;
   logic [CW-1:0] current_color;
   logic [7:0]    render_r, render_g, render_b;

   int n_cmp = 0;
   int n_err = 0;

   color_cursor_compositor dut (
      .clk(clk), .reset(reset), .toggle(toggle),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .request_x(request_x), .request_y(request_y),
      .cursor_visible(cursor_visible),
      .canvas1_color(c1), .canvas1_visible(v1),
      .canvas2_color(c2), .canvas2_visible(v2),
      .canvas3_color(c3), .canvas3_visible(v3),
      .canvas4_color(c4), .canvas4_visible(v4),
      .camera_r(camera_r), .camera_g(camera_g), .camera_b(camera_b),
      .current_color(current_color),
      .render_r(render_r), .render_g(render_g), .render_b(render_b)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one toggle pulse; color must move on the edge that samples it high
   task automatic pulse(input string tag, input logic [CW-1:0] exp);
      toggle = 1'b1;
      tick();
      chk(tag, 24'(current_color), 24'(exp));
      toggle = 1'b0;
      tick();
   endtask

   task automatic px(input string tag, input int x, input int y, input logic [23:0] exp);
      request_x = XW'(x);
      request_y = YW'(y);
      #1;
      chk(tag, {render_r, render_g, render_b}, exp);
   endtask

   logic [CW-1:0] seq [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};

   initial begin
      reset = 1'b1; toggle = 1'b0;
      cursor_x = '0; cursor_y = '0; request_x = '0; request_y = '0;
      cursor_visible = 1'b0;
      c1 = '0; c2 = '0; c3 = '0; c4 = '0;
      v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; v4 = 1'b0;
      camera_r = 8'h12; camera_g = 8'h34; camera_b = 8'h56;
      #1;
      tick(); tick();
      chk("reset_color", 24'(current_color), 24'd1);
      reset = 1'b0;
      tick();
      chk("idle_color", 24'(current_color), 24'd1);

      // eight separate pulses: 2..7 then wrap 1, 2
      for (int i = 0; i < 8; i++) pulse($sformatf("step%0d", i), seq[i]);

      // held toggle: one step only
      toggle = 1'b1;
      tick();
      chk("hold_first", 24'(current_color), 24'd3);
      for (int i = 0; i < 9; i++) tick();
      chk("hold_end", 24'(current_color), 24'd3);
      toggle = 1'b0;
      tick();

      // toggle held through reset release
      toggle = 1'b1; reset = 1'b1;
      tick();
      chk("rst_tog_color", 24'(current_color), 24'd1);
      reset = 1'b0;
      tick(); tick(); tick();
      chk("tog_through_rst", 24'(current_color), 24'd1);
      toggle = 1'b0;
      tick();

      // select red (3)
      pulse("to2", 3'd2);
      pulse("to3", 3'd3);

      // cursor shape around (100,50)
      cursor_x = XW'(100); cursor_y = YW'(50); cursor_visible = 1'b1;
      px("cur_up4",    100, 46, 24'hFF0000);
      px("cur_right4", 104, 50, 24'hFF0000);
      px("cur_center", 100, 50, 24'hFF0000);
      px("cur_down4",  100, 54, 24'hFF0000);
      px("cur_right5", 105, 50, BG);
      px("cur_diag",   101, 51, BG);
      px("cur_up5",    100, 45, BG);

      // clipping at the origin
      cursor_x = '0; cursor_y = '0;
      px("clip_x_wrap", WIDTH-1, 0, BG);
      px("clip_y_wrap", 0, HEIGHT-1, BG);
      px("clip_x4",     4, 0, 24'hFF0000);
      px("clip_origin", 0, 0, 24'hFF0000);

      // layering away from the cursor
      request_x = XW'(300); request_y = YW'(300);
      c1 = 3'd5; v1 = 1'b1; c2 = 3'd6; v2 = 1'b1;
      px("c2_over_c1", 300, 300, 24'hFFFF00);
      v2 = 1'b0;
      px("c2_hidden", 300, 300, 24'h0000FF);
      c1 = 3'd0; c2 = 3'd0; v2 = 1'b1;
      px("transparent", 300, 300, BG);
      c3 = 3'd4; v3 = 1'b1; c4 = 3'd7; v4 = 1'b1;
      px("c4_over_c3", 300, 300, 24'h00FFFF);
      v4 = 1'b0;
      px("c3_only", 300, 300, 24'h00FF00);
      c3 = 3'd0; c4 = 3'd0; v3 = 1'b0;

      // cursor visibility over canvas1 = white
      c1 = 3'd2; v1 = 1'b1;
      cursor_visible = 1'b0;
      px("cur_hidden", 0, 0, 24'hFFFFFF);
      cursor_visible = 1'b1; c4 = 3'd1; v4 = 1'b1;
      px("cur_over_c4", 0, 0, 24'hFF0000);
      px("c4_off_cursor", 2, 2, 24'h000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
